fp_align_seq: RTL

Multi-cycle alignment-shift sequencer for the 96-bit FPU mantissa path. Accepts a mantissa and a right-shift amount. Shifts the mantissa right by at most STEP bits per cycle and accumulates the sticky bit, which is the OR of every bit shifted out. This equals the reduction-OR of bits [amt-1:0] of the original operand. It sits ahead of the adder/rounder and replaces a single-cycle 96-bit barrel shifter plus a wide sticky reduction where timing closure needs it.

---
 rtl/fp_align_seq.sv | 102 ++++++++++
 1 files changed

// File: rtl/fp_align_seq.sv
// Multi-cycle right-shift sequencer with sticky accumulation for the FPU mantissa path.
// Optional feature: define ALIGN_FASTZERO_EN to collapse over-range shifts into a single cycle.
module fp_align_seq #(
    parameter int WID  = 96,
    parameter int STEP = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           ld_i,
    input  logic [6:0]     amt_i,
    input  logic [WID-1:0] a_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [WID-1:0] o,
    output logic           sticky_o
);

`ifdef ALIGN_FASTZERO_EN
    localparam bit FASTZERO = 1'b1;
`else
    localparam bit FASTZERO = 1'b0;
`endif

    localparam logic [6:0] STEP_W = 7'(STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e         state_q, state_d;
    logic [WID-1:0] o_q, o_d;
    logic           sticky_q, sticky_d;
    logic [6:0]     rem_q, rem_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [6:0]     n;
    logic [WID-1:0] out_mask;

    // n never exceeds rem, so rem cannot underflow
    always_comb begin
        n        = (rem_q < STEP_W) ? rem_q : STEP_W;
        out_mask = ~({WID{1'b1}} << n);
    end

    always_comb begin
        state_d  = state_q;
        o_d      = o_q;
        sticky_d = sticky_q;
        rem_d    = rem_q;
        case (state_q)
            IDLE: begin
                if (ld_i) begin
                    o_d      = a_i;
                    rem_d    = amt_i;
                    sticky_d = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (FASTZERO && (int'(rem_q) >= WID)) begin
                    o_d      = '0;
                    sticky_d = sticky_q | (|o_q);
                    rem_d    = '0;
                    state_d  = DONE;
                end else begin
                    sticky_d = sticky_q | (|(o_q & out_mask));
                    o_d      = o_q >> n;
                    rem_d    = rem_q - n;
                    if (rem_q <= STEP_W) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            o_q      <= '0;
            sticky_q <= 1'b0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            o_q      <= o_d;
            sticky_q <= sticky_d;
            rem_q    <= rem_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o        = o_q;
    assign sticky_o = sticky_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule
